// File: rtl/wb_commit_trace.sv
// Commit-trace FIFO between writeback and the difftest/debug trace port.
// Optional macro WB_TRACE_FILTER_EN drops records that write no register.
package wb_commit_trace_pkg;

   typedef struct packed {
      logic [31:0] vaddr;
      logic [31:0] regs_wrdata;
      logic [3:0]  regs_wbe;
      logic [4:0]  regs_waddr;
   } debug_req_t;

   typedef struct packed {
      logic       valid;
      debug_req_t debug_req;
   } pipe_wb_t;

endpackage

module wb_commit_trace
   import wb_commit_trace_pkg::*;
#(
   parameter int DEPTH     = 8,
   parameter int SLACK     = 2,
   parameter int CNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  pipe_wb_t                 pipe_wb,
   output logic                     ready_o,
   output logic                     trace_valid,
   input  logic                     trace_ready,
   output logic [31:0]              trace_pc,
   output logic [3:0]               trace_wbe,
   output logic [4:0]               trace_waddr,
   output logic [31:0]              trace_wdata,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic [CNT_WIDTH-1:0]     overflow_cnt
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam logic [PTR_W:0] READY_LIMIT = (PTR_W+1)'(DEPTH - SLACK);

   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  wbe;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } entry_t;

   entry_t           mem [DEPTH];
   entry_t           head;
   entry_t           wr_entry;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   budget;
   logic             empty;
   logic             full;
   logic             push_req;
   logic             push;
   logic             pop;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                      (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
   assign occupancy = wr_ptr - rd_ptr;

`ifdef WB_TRACE_FILTER_EN
   // Stores and branches carry no register write and never enter the trace.
   assign push_req = pipe_wb.valid && (pipe_wb.debug_req.regs_wbe != 4'b0000);
`else
   assign push_req = pipe_wb.valid;
`endif

   assign pop  = trace_valid && trace_ready;
   assign push = push_req && (!full || pop);

   // Budget includes the record landing this cycle, so the one record that
   // arrives after ready_o falls still fits inside the reserved slack.
   assign budget  = {1'b0, occupancy} + {{PTR_W{1'b0}}, push};
   assign ready_o = (budget <= READY_LIMIT);

   assign wr_entry = '{pc:    pipe_wb.debug_req.vaddr,
                       wbe:   pipe_wb.debug_req.regs_wbe,
                       waddr: pipe_wb.debug_req.regs_waddr,
                       wdata: pipe_wb.debug_req.regs_wrdata};

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         overflow_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push_req && full && !pop && (overflow_cnt != '1))
            overflow_cnt <= overflow_cnt + 1'b1;
      end
   end

   // NOTE: the storage array has no reset; validity lives in the pointers and
   // the outputs are masked while empty, so stale contents are never seen.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[IDX_W-1:0]] <= wr_entry;
   end

   assign head        = mem[rd_ptr[IDX_W-1:0]];
   assign trace_valid = !empty;

   // NOTE: every output gets a default first so no latch can be inferred.
   always_comb begin
      trace_pc    = '0;
      trace_wbe   = '0;
      trace_waddr = '0;
      trace_wdata = '0;
      if (!empty) begin
         trace_pc    = head.pc;
         trace_wbe   = head.wbe;
         trace_waddr = head.waddr;
         trace_wdata = head.wdata;
      end
   end

endmodule

// File: tb/tb_wb_commit_trace.sv
// Bench for wb_commit_trace: queue model checked every cycle plus literal checks.
module tb_wb_commit_trace;
   import wb_commit_trace_pkg::*;

   logic        clk;
   logic        rst;
   pipe_wb_t    pipe_wb;
   logic        ready_o;
   logic        trace_valid;
   logic        trace_ready;
   logic [31:0] trace_pc;
   logic [3:0]  trace_wbe;
   logic [4:0]  trace_waddr;
   logic [31:0] trace_wdata;
   logic [3:0]  occupancy;
   logic [15:0] overflow_cnt;

   wb_commit_trace #(.DEPTH(8), .SLACK(2), .CNT_WIDTH(16)) dut (
      .clk(clk),
      .rst(rst),
      .pipe_wb(pipe_wb),
      .ready_o(ready_o),
      .trace_valid(trace_valid),
      .trace_ready(trace_ready),
      .trace_pc(trace_pc),
      .trace_wbe(trace_wbe),
      .trace_waddr(trace_waddr),
      .trace_wdata(trace_wdata),
      .occupancy(occupancy),
      .overflow_cnt(overflow_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [3:0]  wbe;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } rec_t;

   rec_t        mq[$];
   int unsigned m_ovf;
   bit          run;
   int          n_checks;
   int          n_fail;
   bit          exp_pop;
   bit          exp_req;
   bit          exp_push;
   rec_t        nr;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_wb(input logic v, input logic [31:0] pc, input logic [31:0] wd,
                         input logic [3:0] wbe, input logic [4:0] wa);
      pipe_wb.valid                 = v;
      pipe_wb.debug_req.vaddr       = pc;
      pipe_wb.debug_req.regs_wrdata = wd;
      pipe_wb.debug_req.regs_wbe    = wbe;
      pipe_wb.debug_req.regs_waddr  = wa;
   endtask

   task automatic idle();
      set_wb(1'b0, 32'h0, 32'h0, 4'h0, 5'h0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Model: a FIFO of up to 8 records, evaluated mid-cycle for the coming edge.
   always @(negedge clk) begin
      if (run && rst) begin
         exp_pop = (mq.size() != 0) && trace_ready;
`ifdef WB_TRACE_FILTER_EN
         exp_req = pipe_wb.valid && (pipe_wb.debug_req.regs_wbe != 4'h0);
`else
         exp_req = pipe_wb.valid;
`endif
         exp_push = exp_req && ((mq.size() < 8) || exp_pop);
         check("cmp_valid", trace_valid, mq.size() != 0);
         check("cmp_occ", occupancy, mq.size());
         check("cmp_ovf", overflow_cnt, m_ovf);
         check("cmp_ready", ready_o, (mq.size() + int'(exp_push)) <= 6);
         if (mq.size() != 0) begin
            check("cmp_pc", trace_pc, mq[0].pc);
            check("cmp_wbe", trace_wbe, mq[0].wbe);
            check("cmp_waddr", trace_waddr, mq[0].waddr);
            check("cmp_wdata", trace_wdata, mq[0].wdata);
         end else begin
            check("cmp_zero", {trace_pc, trace_wdata}, 64'h0);
         end
         if (exp_pop) void'(mq.pop_front());
         if (exp_push) begin
            nr.pc    = pipe_wb.debug_req.vaddr;
            nr.wbe   = pipe_wb.debug_req.regs_wbe;
            nr.waddr = pipe_wb.debug_req.regs_waddr;
            nr.wdata = pipe_wb.debug_req.regs_wrdata;
            mq.push_back(nr);
         end else if (exp_req && m_ovf < 32'hFFFF) begin
            m_ovf++;
         end
      end
   end

   bit   stop;
   logic rdy;

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      run         = 0;
      m_ovf       = 0;
      rst         = 1'b0;
      trace_ready = 1'b0;
      idle();
      #2;
      check("rst_occ", occupancy, 0);
      check("rst_valid", trace_valid, 0);
      check("rst_ready", ready_o, 1);
      check("rst_ovf", overflow_cnt, 0);
      check("rst_pc", trace_pc, 0);
      @(posedge clk);
      #3 rst = 1'b1;
      run = 1;
      step();

      // Reset mid-stream
      for (int i = 0; i < 3; i++) begin
         set_wb(1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF, 5'(i + 1));
         step();
      end
      idle();
      check("mid_occ_before", occupancy, 3);
      #2 rst = 1'b0;
      #1;
      check("mid_occ", occupancy, 0);
      check("mid_valid", trace_valid, 0);
      check("mid_ready", ready_o, 1);
      mq.delete();
      m_ovf = 0;
      @(posedge clk);
      #3 rst = 1'b1;
      step();

      // Single record
      trace_ready = 1'b1;
      set_wb(1'b1, 32'hBFC0_0000, 32'h1234_5678, 4'hF, 5'd8);
      step();
      idle();
      check("single_valid", trace_valid, 1);
      check("single_pc", trace_pc, 32'hBFC0_0000);
      check("single_wdata", trace_wdata, 32'h1234_5678);
      check("single_wbe", trace_wbe, 4'hF);
      check("single_waddr", trace_waddr, 5'd8);
      step();
      check("single_occ", occupancy, 0);
      check("single_drained", trace_valid, 0);

      // Back-pressure: writeback stops after the cycle ready_o drops
      trace_ready = 1'b0;
      stop = 0;
      for (int i = 0; i < 10; i++) begin
         if (!stop) begin
            set_wb(1'b1, 32'h1000 + 32'(4 * i), 32'hB0 + 32'(i), 4'hF, 5'(i + 10));
            #1;
            rdy = ready_o;
            check("bp_ready", rdy, i < 6);
            step();
            if (!rdy) stop = 1;
         end
      end
      idle();
      step();
      check("bp_occ", occupancy, 7);
      check("bp_ovf", overflow_cnt, 0);
      check("bp_ready_low", ready_o, 0);
      check("bp_head", trace_pc, 32'h1000);
      trace_ready = 1'b1;
      repeat (9) step();
      check("bp_drain", occupancy, 0);

      // Forced overflow
      trace_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         set_wb(1'b1, 32'h2000 + 32'(4 * i), 32'hC0 + 32'(i), 4'(i | 1), 5'(i));
         step();
      end
      idle();
      check("ovf_occ", occupancy, 8);
      check("ovf_cnt", overflow_cnt, 2);
      check("ovf_head", trace_pc, 32'h2000);
      check("ovf_ready", ready_o, 0);

      // Full with simultaneous push and pop, wrapping the pointers
      trace_ready = 1'b1;
      for (int j = 0; j < 20; j++) begin
         set_wb(1'b1, 32'h3000 + 32'(4 * j), 32'hD0 + 32'(j), 4'hF, 5'(j));
         step();
         check("full_occ", occupancy, 8);
         check("full_ovf", overflow_cnt, 2);
         if (j == 3) check("full_head4", trace_pc, 32'h2010);
      end
      idle();
      check("wrap_head", trace_pc, 32'h3030);
      check("wrap_wdata", trace_wdata, 32'hDC);
      repeat (9) step();
      check("wrap_drain", occupancy, 0);
      check("wrap_ovf", overflow_cnt, 2);

      // Alternating register-writing and non-writing records
      trace_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         set_wb(1'b1, 32'h4000 + 32'(4 * k), 32'hE0 + 32'(k),
                (k % 2 == 0) ? 4'hF : 4'h0, 5'(k + 1));
         step();
      end
      idle();
`ifdef WB_TRACE_FILTER_EN
      check("alt_occ", occupancy, 3);
`else
      check("alt_occ", occupancy, 6);
`endif
      check("alt_head", trace_pc, 32'h4000);
      trace_ready = 1'b1;
      step();
`ifdef WB_TRACE_FILTER_EN
      check("alt_second", trace_pc, 32'h4008);
`else
      check("alt_second", trace_pc, 32'h4004);
`endif
      repeat (7) step();
      check("alt_drain", occupancy, 0);
      check("alt_ovf", overflow_cnt, 2);

      run = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_commit_trace.md
Name: wb_commit_trace

Overview:
- Buffers retired-instruction commit records downstream of the writeback stage.
- Each cycle it samples the registered writeback bundle (pipe_wb). When the bundle is valid it enqueues {pc, wbe, waddr, wdata} into a FIFO.
- It presents the FIFO head on a valid/ready trace port that drives the difftest/debug trace interface.
- It back-pressures the writeback stage through ready_o, which feeds that stage's ready_i.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of two, >= 4.
- SLACK, 2, free entries reserved when ready_o is deasserted; covers the one-cycle registered lag of pipe_wb.
- CNT_WIDTH, 16, width of the saturating overflow counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pipe_wb  in  pipe_wb_t  registered writeback bundle; uses valid and debug_req.{vaddr, regs_wrdata, regs_wbe, regs_waddr}.
- ready_o  out  1  writeback may advance; connects to the writeback stage's ready_i.
- trace_valid  out  1  head entry available.
- trace_ready  in  1  consumer accepts the head.
- trace_pc  out  32  head vaddr.
- trace_wbe  out  4  head register byte-enables.
- trace_waddr  out  5  head destination register.
- trace_wdata  out  32  head write data.
- occupancy  out  $clog2(DEPTH)+1  current entry count.
- overflow_cnt  out  CNT_WIDTH  dropped records, saturating.

Behaviour:
- Reset (rst=0, asynchronous):
  - rd_ptr = wr_ptr = 0; occupancy = 0; overflow_cnt = 0.
  - trace_valid = 0; trace_* data = 0; ready_o = 1.
  - Reset release is synchronous to clk. Reset asserted mid-operation discards all entries immediately.
- Pointers: $clog2(DEPTH)+1 bits, wrap bit included.
  - empty = (wr_ptr == rd_ptr).
  - full = index bits equal and wrap bits differ.
  - occupancy = wr_ptr - rd_ptr, modulo 2^(ptr width).
- Push:
  - push_req = pipe_wb.valid.
  - push = push_req && (!full || pop).
  - On push, write the entry at wr_ptr[idx] and increment wr_ptr.
  - Entries with wbe=0 (stores, branches) are still pushed.
- Pop:
  - pop = trace_valid && trace_ready; on pop, increment rd_ptr.
- Simultaneous push and pop:
  - Allowed at any occupancy, including full.
  - At full, the pushed entry takes the slot freed by the pop; occupancy is unchanged.
- Overflow:
  - If push_req && full && !pop, the record is dropped and overflow_cnt increments.
  - overflow_cnt saturates at all-ones and never wraps.
  - FIFO contents are unaffected.
- Output:
  - Show-ahead: trace_* reflect mem[rd_ptr[idx]] combinationally; trace_valid = !empty.
  - trace_* data are zero-masked when empty.
- Latency: a record valid on pipe_wb in cycle N is visible on trace_valid in cycle N+1 (no bypass from empty).
- Flow control:
  - ready_o = (occupancy + push) <= DEPTH - SLACK, computed combinationally from state plus the current push.
  - The writeback stage zeroes pipe_wb when not ready, so at most one record arrives after ready_o falls. SLACK=2 guarantees no drop when the consumer stalls indefinitely.
- trace_ready is ignored while empty.

Optional Feature:
- Macro: WB_TRACE_FILTER_EN.
- Defined:
  - Records with regs_wbe == 4'b0000 are not enqueued and not counted as overflow.
  - They still consume no ready_o budget.
  - occupancy counts only register-writing records.
- Undefined: every valid pipe_wb record is enqueued, as described above.

Test Plan:
- Reset mid-stream:
  - Stimulus: enqueue 3 records, then assert rst=0 asynchronously between clock edges.
  - Required: occupancy=0, trace_valid=0 and ready_o=1 immediately, with no clock edge needed.
- Single record:
  - Stimulus: pipe_wb.valid=1 with vaddr=0xBFC00000, wrdata=0x12345678, wbe=4'hF, waddr=5'd8; trace_ready=1.
  - Required: trace_valid=1 exactly one cycle later with matching fields, popped that cycle; occupancy back to 0.
- Back-pressure, DEPTH=8:
  - Stimulus: trace_ready=0, push every cycle.
  - Required: ready_o falls when occupancy reaches 6; the trailing record brings occupancy to 7; overflow_cnt stays 0.
- Forced overflow:
  - Stimulus: ignore ready_o, push 10 records with trace_ready=0.
  - Required: occupancy=8, overflow_cnt=2; head still holds record 0.
- Full with simultaneous push and pop:
  - Stimulus: occupancy=8, trace_ready=1, pipe_wb.valid=1 for 4 cycles.
  - Required: occupancy stays 8, in-order output, overflow_cnt unchanged; pointer wrap verified over 20 cycles.
- Filter (WB_TRACE_FILTER_EN defined):
  - Stimulus: push alternating wbe=4'hF and wbe=4'h0, 6 records.
  - Required: only 3 records appear on the trace port, in order.
